rle_expander: RTL and testbench

Streaming run-length decoder: accepts (data, count) run pairs on a valid/ready input channel and expands each pair into `count` copies of `data` on a valid/ready byte output channel, at one byte per cycle. It sits downstream of `rle_encoder` output (after any transport/buffering) and replaces ad-hoc decoding with a back-pressure-aware, gap-free stream. Packet boundaries are carried by a `last` flag on both channels.

---
 rtl/rle_expander.sv | 112 +++++++++++
 tb/tb_rle_expander.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_expander.sv
// Streaming run-length decoder: expands (data, count) pairs into count copies of data,
// one byte per cycle, with valid/ready on both sides and packet last/done signalling.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no run loaded; ready for a pair, output channel idle
// ST_EXPAND | emitting r_cur_data; r_remain bytes of the run still owed
module rle_expander #(
   parameter int DW  = 8,
   parameter int CW  = 8,
   parameter int BCW = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_in_valid,
   output logic           o_in_ready,
   input  logic [DW-1:0]  i_in_data,
   input  logic [CW-1:0]  i_in_count,
   input  logic           i_in_last,
   output logic           o_out_valid,
   input  logic           i_out_ready,
   output logic [DW-1:0]  o_out_data,
   output logic           o_out_last,
   output logic           o_done,
   output logic [BCW-1:0] o_byte_cnt
);

   typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [DW-1:0]   r_cur_data;
   logic [DW-1:0]   w_cur_data_nxt;
   logic [CW-1:0]   r_remain;
   logic [CW-1:0]   w_remain_nxt;
   logic            r_cur_last;
   logic            w_cur_last_nxt;
   logic            r_done;
   logic            w_done_nxt;
   logic [BCW-1:0]  r_byte_cnt;

   logic            w_rem_one;
   logic            w_byte_xfer;
   logic            w_pair_xfer;
   logic            w_zero_pair;

   assign w_rem_one   = (r_remain == CW'(1));
   assign o_out_valid = (r_state == ST_EXPAND);
   assign o_out_data  = r_cur_data;
   assign o_out_last  = o_out_valid && r_cur_last && w_rem_one;
   assign w_byte_xfer = o_out_valid && i_out_ready;
   // Ready on the final byte of a run lets the next run follow without a bubble.
   assign o_in_ready  = i_rst && ((r_state == ST_IDLE) || (w_byte_xfer && w_rem_one));
   assign w_pair_xfer = i_in_valid && o_in_ready;
   assign w_zero_pair = (i_in_count == '0);
   assign o_done      = r_done;
   assign o_byte_cnt  = r_byte_cnt;

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_data_nxt = r_cur_data;
      w_remain_nxt   = r_remain;
      w_cur_last_nxt = r_cur_last;
      w_done_nxt     = 1'b0;

      if (w_byte_xfer) begin
         if (w_rem_one) begin
            w_state_nxt = ST_IDLE;
         end else begin
            w_remain_nxt = r_remain - CW'(1);
         end
         if (o_out_last) begin
            w_done_nxt = 1'b1;
         end
      end

      if (w_pair_xfer) begin
         if (w_zero_pair) begin
            w_state_nxt = ST_IDLE;
            if (i_in_last) begin
               w_done_nxt = 1'b1;
            end
         end else begin
            w_state_nxt    = ST_EXPAND;
            w_cur_data_nxt = i_in_data;
            w_remain_nxt   = i_in_count;
            w_cur_last_nxt = i_in_last;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state    <= ST_IDLE;
         r_cur_data <= '0;
         r_remain   <= '0;
         r_cur_last <= 1'b0;
         r_done     <= 1'b0;
         r_byte_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_data <= w_cur_data_nxt;
         r_remain   <= w_remain_nxt;
         r_cur_last <= w_cur_last_nxt;
         r_done     <= w_done_nxt;
         if (w_byte_xfer) begin
            r_byte_cnt <= r_byte_cnt + BCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_rle_expander.sv
// Directed bench for rle_expander: vector table of single pairs plus hand-built
// sequences for back-to-back runs, back-pressure, zero counts, max run and reset.
module tb_rle_expander;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_count;
   logic        in_last;
   logic        out_ready;

   logic        in_ready,  out_valid,  out_last,  done;
   logic [7:0]  out_data;
   logic [15:0] byte_cnt;

   logic        n_in_ready, n_out_valid, n_out_last, n_done;
   logic [7:0]  n_out_data;
   logic [7:0]  n_byte_cnt;

   rle_expander #(.DW(8), .CW(8), .BCW(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .i_in_count(in_count), .i_in_last(in_last),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_last(out_last), .o_done(done), .o_byte_cnt(byte_cnt));

   // Narrow-counter copy on the same stimulus so counter wrap is reachable quickly.
   rle_expander #(.DW(8), .CW(8), .BCW(8)) u_dut_n (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(n_in_ready),
      .i_in_data(in_data), .i_in_count(in_count), .i_in_last(in_last),
      .o_out_valid(n_out_valid), .i_out_ready(out_ready), .o_out_data(n_out_data),
      .o_out_last(n_out_last), .o_done(n_done), .o_byte_cnt(n_byte_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
      int         c;
   } rec_t;

   typedef struct {
      logic [7:0] d;
      logic [7:0] cnt;
      logic       l;
      int         nb;
      int         nd;
   } vec_t;

   rec_t q[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   rdy_cnt = 0;
   int   stall_seen = 0;
   int   stall_err = 0;
   logic prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_last = 1'b0;

   int n_checks = 0;
   int n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) begin
            stall_seen = stall_seen + 1;
            if (!out_valid || out_data !== prev_data || out_last !== prev_last)
               stall_err = stall_err + 1;
         end
         if (out_valid && out_ready) q.push_back('{d: out_data, l: out_last, c: cyc});
         if (out_valid && in_ready) rdy_cnt = rdy_cnt + 1;
         if (done) done_cnt = done_cnt + 1;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Present a pair, wait for acceptance; returns at posedge+1 after the transfer.
   task automatic send_pair(input logic [7:0] d, input logic [7:0] c, input logic l,
                            input bit hold, output int acc);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_count = c;
      in_last  = l;
      acc = -1;
      for (t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (t >= 1000) chk("send_timeout", 32'(0), 32'(1));
      else acc = cyc;
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      for (t = 0; t < 600; t++) begin
         @(negedge clk);
         #1;
         if (!out_valid) break;
      end
      if (t >= 600) chk("drain_timeout", 32'(0), 32'(1));
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   vec_t vt[6];
   int   acc, acc0, base, d0, r0, ok;
   logic [15:0] bc0;
   logic [7:0]  exp_seq[$];

   initial begin
      vt[0] = '{d: 8'hA5, cnt: 8'd3, l: 1'b1, nb: 3, nd: 1};
      vt[1] = '{d: 8'h3C, cnt: 8'd1, l: 1'b0, nb: 1, nd: 0};
      vt[2] = '{d: 8'h7F, cnt: 8'd0, l: 1'b1, nb: 0, nd: 1};
      vt[3] = '{d: 8'h12, cnt: 8'd0, l: 1'b0, nb: 0, nd: 0};
      vt[4] = '{d: 8'hE7, cnt: 8'd5, l: 1'b1, nb: 5, nd: 1};
      vt[5] = '{d: 8'h00, cnt: 8'd2, l: 1'b1, nb: 2, nd: 1};

      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(0));
      chk("rst_out_last", 32'(out_last), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_byte_cnt", 32'(byte_cnt), 32'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;

      // Single pairs from idle
      for (int k = 0; k < 6; k++) begin
         base = q.size(); d0 = done_cnt; bc0 = byte_cnt;
         send_pair(vt[k].d, vt[k].cnt, vt[k].l, 1'b0, acc);
         drain();
         chk("tbl_nbytes", 32'(q.size() - base), 32'(vt[k].nb));
         for (int i = base; i < q.size(); i++) begin
            chk("tbl_data", 32'(q[i].d), 32'(vt[k].d));
            chk("tbl_last", 32'(q[i].l), 32'(vt[k].l && (i == q.size() - 1)));
         end
         if (q.size() > base) chk("tbl_latency", 32'(q[base].c), 32'(acc + 1));
         chk("tbl_done", 32'(done_cnt - d0), 32'(vt[k].nd));
         chk("tbl_byte_cnt", 32'(16'(byte_cnt - bc0)), 32'(vt[k].nb));
      end

      // Back-to-back runs with in_valid held high
      base = q.size(); d0 = done_cnt; r0 = rdy_cnt;
      send_pair(8'h11, 8'd2, 1'b0, 1'b1, acc0);
      send_pair(8'h22, 8'd1, 1'b0, 1'b1, acc);
      send_pair(8'h33, 8'd4, 1'b1, 1'b0, acc);
      drain();
      exp_seq = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
      chk("b2b_nbytes", 32'(q.size() - base), 32'(7));
      ok = 1;
      for (int i = 0; i < 7 && base + i < q.size(); i++) begin
         if (q[base + i].d !== exp_seq[i] || q[base + i].c != q[base].c + i) ok = 0;
         if (q[base + i].l !== (i == 6)) ok = 0;
      end
      chk("b2b_seq_gapfree", 32'(ok), 32'(1));
      if (q.size() > base) chk("b2b_latency", 32'(q[base].c), 32'(acc0 + 1));
      chk("b2b_ready_cycles", 32'(rdy_cnt - r0), 32'(3));
      chk("b2b_done", 32'(done_cnt - d0), 32'(1));

      // Back-pressure with a second pair waiting
      base = q.size(); d0 = done_cnt;
      fork
         begin
            send_pair(8'h5A, 8'd4, 1'b0, 1'b1, acc);
            send_pair(8'h66, 8'd1, 1'b1, 1'b0, acc);
         end
         begin
            for (int i = 0; i < 30; i++) begin
               @(posedge clk);
               #1 out_ready = (i % 4 == 0) || (i % 4 == 3);
            end
            out_ready = 1'b1;
         end
      join
      drain();
      exp_seq = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h66};
      chk("bp_nbytes", 32'(q.size() - base), 32'(5));
      ok = 1;
      for (int i = 0; i < 5 && base + i < q.size(); i++)
         if (q[base + i].d !== exp_seq[i] || q[base + i].l !== (i == 4)) ok = 0;
      chk("bp_seq", 32'(ok), 32'(1));
      chk("bp_stall_seen", 32'(stall_seen > 0), 32'(1));
      chk("bp_stall_stable", 32'(stall_err), 32'(0));
      chk("bp_done", 32'(done_cnt - d0), 32'(1));

      // Zero-count pair between runs
      base = q.size(); d0 = done_cnt; bc0 = byte_cnt;
      send_pair(8'h01, 8'd2, 1'b0, 1'b1, acc);
      send_pair(8'h02, 8'd0, 1'b0, 1'b1, acc);
      send_pair(8'h03, 8'd1, 1'b1, 1'b0, acc);
      drain();
      exp_seq = '{8'h01, 8'h01, 8'h03};
      chk("zero_nbytes", 32'(q.size() - base), 32'(3));
      ok = 1;
      for (int i = 0; i < 3 && base + i < q.size(); i++)
         if (q[base + i].d !== exp_seq[i] || q[base + i].l !== (i == 2)) ok = 0;
      chk("zero_seq", 32'(ok), 32'(1));
      chk("zero_done", 32'(done_cnt - d0), 32'(1));
      chk("zero_byte_cnt", 32'(16'(byte_cnt - bc0)), 32'(3));

      // Max run, then one byte to wrap the narrow counter
      do_reset();
      base = q.size(); d0 = done_cnt;
      send_pair(8'hFF, 8'd255, 1'b1, 1'b0, acc);
      drain();
      chk("max_nbytes", 32'(q.size() - base), 32'(255));
      ok = 1;
      for (int i = base; i < q.size(); i++)
         if (q[i].d !== 8'hFF || q[i].l !== (i == base + 254)) ok = 0;
      chk("max_data_last", 32'(ok), 32'(1));
      chk("max_done", 32'(done_cnt - d0), 32'(1));
      chk("max_byte_cnt", 32'(byte_cnt), 32'(255));
      chk("max_byte_cnt_n", 32'(n_byte_cnt), 32'(255));
      send_pair(8'h01, 8'd1, 1'b1, 1'b0, acc);
      drain();
      chk("wrap_byte_cnt_n", 32'(n_byte_cnt), 32'(0));
      chk("wrap_byte_cnt", 32'(byte_cnt), 32'(256));

      // Reset in the middle of a run
      base = q.size(); d0 = done_cnt;
      send_pair(8'h44, 8'd10, 1'b1, 1'b0, acc);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         #1;
         if (q.size() - base >= 4) break;
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
      chk("mid_rst_byte_cnt", 32'(byte_cnt), 32'(0));
      chk("mid_rst_byte_cnt_n", 32'(n_byte_cnt), 32'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_rst_nbytes", 32'(q.size() - base), 32'(4));
      chk("mid_rst_no_done", 32'(done_cnt - d0), 32'(0));
      chk("mid_rst_idle", 32'(out_valid), 32'(0));
      @(posedge clk);
      #1;
      base = q.size();
      send_pair(8'h55, 8'd2, 1'b1, 1'b0, acc);
      drain();
      chk("after_rst_nbytes", 32'(q.size() - base), 32'(2));
      ok = 1;
      for (int i = base; i < q.size(); i++)
         if (q[i].d !== 8'h55 || q[i].l !== (i == base + 1)) ok = 0;
      chk("after_rst_seq", 32'(ok), 32'(1));
      chk("after_rst_byte_cnt", 32'(byte_cnt), 32'(2));
      chk("after_rst_done", 32'(done_cnt - d0), 32'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
